// File: rtl/param_counter.sv
// Up/down counter with a programmable upper bound, wrap or saturate at either end,
// a synchronous clamped load, a one-cycle wrap pulse and a sticky "blocked at limit" flag.
module param_counter #(
    parameter int          WIDTH   = 4,
    parameter int unsigned MAX_VAL = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             at_limit_q, at_limit_d;

    logic             at_max;
    logic             at_zero;
    logic             hit_bound;
    logic [WIDTH-1:0] load_clamped;

    assign at_max       = (count_q == MAX_Q);
    assign at_zero      = (count_q == ZERO_Q);
    assign hit_bound    = up ? at_max : at_zero;
    assign load_clamped = (load_val > MAX_Q) ? MAX_Q : load_val;

    // Bound is compared explicitly, so MAX_VAL = 2^WIDTH-1 never relies on overflow.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        at_limit_d = at_limit_q;
        if (load) begin
            count_d    = load_clamped;
            at_limit_d = 1'b0;
        end else if (en) begin
            if (hit_bound) begin
                if (sat) begin
                    at_limit_d = 1'b1;
                end else begin
                    count_d = up ? ZERO_Q : MAX_Q;
                    wrap_d  = 1'b1;
                end
            end else begin
                count_d = up ? (count_q + ONE_Q) : (count_q - ONE_Q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            at_limit_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            at_limit_q <= at_limit_d;
        end
    end

    // Terminal count is combinational so it can qualify the same edge that wraps.
    assign tc       = en & ~load & hit_bound;
    assign q        = count_q;
    assign wrap     = wrap_q;
    assign at_limit = at_limit_q;

endmodule

// File: tb/tb_param_counter.sv
// Bench for param_counter: two instances (MAX_VAL=9 and 15) share directed stimulus,
// an arithmetic reference model is compared every cycle, plus hand-computed literal checks.
module tb_param_counter;

    logic       clk;
    logic       rst, en, up, sat, load;
    logic [3:0] load_val;
    logic [3:0] q9, q15;
    logic       tc9, tc15, wr9, wr15, al9, al15;

    int n_asr  = 0;
    int n_fail = 0;
    int n_tx   = 0;
    bit chk_en = 1'b0;

    int mq[2];
    int mw[2];
    int ml[2];
    int mmax[2] = '{9, 15};

    param_counter #(.WIDTH(4), .MAX_VAL(9)) dut9 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .q(q9), .tc(tc9), .wrap(wr9), .at_limit(al9)
    );

    param_counter #(.WIDTH(4), .MAX_VAL(15)) dut15 (
        .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .q(q15), .tc(tc15), .wrap(wr15), .at_limit(al15)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_asr++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the count lives in the ring 0..max; a step that would leave it
    // either sticks (sat) or is taken modulo max+1 (wrap).
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int nq;
            mw[k] = 0;
            if (rst) begin
                mq[k] = 0;
                ml[k] = 0;
            end else if (load) begin
                mq[k] = (int'(load_val) > mmax[k]) ? mmax[k] : int'(load_val);
                ml[k] = 0;
            end else if (en) begin
                nq = mq[k] + (up ? 1 : -1);
                if (nq < 0 || nq > mmax[k]) begin
                    if (sat) ml[k] = 1;
                    else begin
                        mq[k] = (nq + mmax[k] + 1) % (mmax[k] + 1);
                        mw[k] = 1;
                    end
                end else begin
                    mq[k] = nq;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic etc0, etc1;
            etc0 = en && !load && ((up && mq[0] == 9) || (!up && mq[0] == 0));
            etc1 = en && !load && ((up && mq[1] == 15) || (!up && mq[1] == 0));
            chk("m9_q",  32'(q9),  32'(mq[0]));
            chk("m9_tc", 32'(tc9), 32'(etc0));
            chk("m9_wrap", 32'(wr9), 32'(mw[0]));
            chk("m9_at_limit", 32'(al9), 32'(ml[0]));
            chk("m15_q",  32'(q15),  32'(mq[1]));
            chk("m15_tc", 32'(tc15), 32'(etc1));
            chk("m15_wrap", 32'(wr15), 32'(mw[1]));
            chk("m15_at_limit", 32'(al15), 32'(ml[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        n_tx++;
        $display("tx %0d: rst=%0b load=%0b lv=%0d en=%0b up=%0b sat=%0b -> q9=%0d wr9=%0b al9=%0b q15=%0d wr15=%0b al15=%0b",
                 n_tx, rst, load, load_val, en, up, sat, q9, wr9, al9, q15, wr15, al15);
    endtask

    task automatic set_in(input logic r, input logic l, input logic [3:0] lv,
                          input logic e, input logic u, input logic s);
        rst = r; load = l; load_val = lv; en = e; up = u; sat = s;
    endtask

    initial begin
        int exp31[5] = '{2, 1, 0, 9, 8};
        int e30;

        set_in(1, 0, 4'd0, 0, 1, 0);
        tick();
        tick();
        chk_en = 1'b1;
        #1;
        chk("rst_q", 32'(q9), 32'd0);
        chk("rst_wrap", 32'(wr9), 32'd0);
        chk("rst_at_limit", 32'(al9), 32'd0);

        // count up with wrap: 0..9,0,1
        set_in(0, 0, 4'd0, 1, 1, 0);
        for (int i = 0; i < 12; i++) begin
            e30 = (i < 10) ? i : i - 10;
            #1;
            chk("up_wrap_q", 32'(q9), 32'(e30));
            chk("up_wrap_tc", 32'(tc9), 32'(e30 == 9));
            chk("up_wrap_pulse", 32'(wr9), 32'(i == 10));
            tick();
        end

        // load 2 then count down through zero
        set_in(0, 1, 4'd2, 0, 0, 0);
        tick();
        set_in(0, 0, 4'd0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("down_q", 32'(q9), 32'(exp31[i]));
            chk("down_tc", 32'(tc9), 32'(i == 2));
            chk("down_wrap", 32'(wr9), 32'(i == 3));
            if (i < 4) tick();
        end

        // clamped load, then saturate at max
        set_in(0, 1, 4'd12, 0, 1, 1);
        tick();
        #1;
        chk("load_clamp_q", 32'(q9), 32'd9);
        chk("load_noclamp_q15", 32'(q15), 32'd12);
        set_in(0, 0, 4'd0, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            #1;
            chk("sat_hold_q", 32'(q9), 32'd9);
            chk("sat_at_limit", 32'(al9), 32'd1);
        end
        set_in(0, 1, 4'd3, 0, 1, 1);
        tick();
        #1;
        chk("load_clear_q", 32'(q9), 32'd3);
        chk("load_clear_at_limit", 32'(al9), 32'd0);

        // load wins over count, then hold
        set_in(0, 1, 4'd5, 0, 1, 0);
        tick();
        set_in(0, 1, 4'd7, 1, 1, 0);
        #1;
        chk("load_prio_tc", 32'(tc9), 32'd0);
        tick();
        #1;
        chk("load_prio_q", 32'(q9), 32'd7);
        set_in(0, 0, 4'd0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            #1;
            chk("hold_q", 32'(q9), 32'd7);
            chk("hold_tc", 32'(tc9), 32'd0);
        end

        // reset beats load mid-count
        set_in(0, 1, 4'd5, 0, 1, 0);
        tick();
        set_in(0, 0, 4'd0, 1, 1, 0);
        tick();
        #1;
        chk("pre_rst_q", 32'(q9), 32'd6);
        set_in(1, 1, 4'd4, 1, 1, 0);
        tick();
        #1;
        chk("rst_prio_q", 32'(q9), 32'd0);
        chk("rst_prio_wrap", 32'(wr9), 32'd0);
        chk("rst_prio_at_limit", 32'(al9), 32'd0);
        set_in(1, 0, 4'd0, 1, 0, 0);
        #1;
        chk("rst_tc", 32'(tc9), 32'd1);
        tick();
        set_in(0, 1, 4'd9, 0, 1, 1);
        tick();
        set_in(0, 0, 4'd0, 1, 1, 1);
        tick();
        #1;
        chk("sat_set_at_limit", 32'(al9), 32'd1);
        set_in(1, 0, 4'd0, 1, 1, 0);
        tick();
        #1;
        chk("rst_vs_wrap_q", 32'(q9), 32'd0);
        chk("rst_vs_wrap_pulse", 32'(wr9), 32'd0);
        chk("rst_clear_at_limit", 32'(al9), 32'd0);

        // full-range counter at 15
        set_in(0, 1, 4'd15, 0, 1, 0);
        tick();
        #1;
        chk("full_load_q15", 32'(q15), 32'd15);
        set_in(0, 0, 4'd0, 1, 1, 0);
        tick();
        #1;
        chk("full_wrap_q15", 32'(q15), 32'd0);
        chk("full_wrap_pulse15", 32'(wr15), 32'd1);
        set_in(0, 1, 4'd15, 0, 1, 1);
        tick();
        set_in(0, 0, 4'd0, 1, 1, 1);
        tick();
        #1;
        chk("full_sat_q15", 32'(q15), 32'd15);
        chk("full_sat_at_limit15", 32'(al15), 32'd1);

        // mixed traffic, checked against the model every cycle
        for (int i = 0; i < 400; i++) begin
            set_in(logic'($urandom_range(0, 39) == 0), logic'($urandom_range(0, 7) == 0),
                   4'($urandom_range(0, 15)), logic'($urandom_range(0, 3) != 0),
                   logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
            tick();
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_asr, n_fail);
        $finish;
    end

endmodule

// File: doc/param_counter.md
PARAM_COUNTER -- requirements
Module: param_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter bit width (legal range 1..32).
REQ-002 SHALL have parameter MAX_VAL, default 15, highest count value; 0 < MAX_VAL <= 2^WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port up  input  1  direction: 1 = count up, 0 = count down.
REQ-007 SHALL have port sat  input  1  boundary mode: 1 = saturate, 0 = wrap.
REQ-008 SHALL have port load  input  1  synchronous load strobe.
REQ-009 SHALL have port load_val  input  WIDTH  value to load.
REQ-010 SHALL have port q  output  WIDTH  registered count.
REQ-011 SHALL have port tc  output  1  terminal-count indicator, combinational.
REQ-012 SHALL have port wrap  output  1  registered one-cycle pulse after a wrap.
REQ-013 SHALL have port at_limit  output  1  registered sticky flag: a saturating edge was blocked.

Function
REQ-014 SHALL apply per-edge priority: rst > load > en > hold.
REQ-015 SHALL set q to load_val on load=1 when load_val <= MAX_VAL, and to MAX_VAL when load_val > MAX_VAL; en, up and sat are ignored that cycle.
REQ-016 SHALL, with en=1, up=1 and q < MAX_VAL, set q to q+1 (single-cycle latency).
REQ-017 SHALL, with en=1, up=0 and q > 0, set q to q-1.
REQ-018 SHALL, with en=1, up=1, q == MAX_VAL: sat=0 sets q to 0; sat=1 holds q.
REQ-019 SHALL, with en=1, up=0, q == 0: sat=0 sets q to MAX_VAL; sat=1 holds q.
REQ-020 SHALL hold q when en=0 and load=0.
REQ-021 SHALL assert tc = en & ~load & ((up & q==MAX_VAL) | (~up & q==0)), with no register delay.
REQ-022 SHALL assert wrap for exactly the one cycle after an edge on which REQ-018/REQ-019 wrapped (sat=0); otherwise wrap=0.
REQ-023 SHALL set at_limit on an edge on which REQ-018/REQ-019 held q because sat=1; at_limit SHALL stay set until load=1 or rst=1 clears it; a load and a set condition cannot coincide.
REQ-024 SHALL never produce q > MAX_VAL, including when MAX_VAL < 2^WIDTH-1; all arithmetic is WIDTH bits with no carry out.
REQ-025 SHALL let direction or sat change on any cycle; each edge uses the current-cycle values only.
REQ-026 SHALL handle MAX_VAL = 2^WIDTH-1 identically to smaller MAX_VAL, with no dependence on natural overflow.

Reset
REQ-027 SHALL, on a rising edge with rst=1, set q=0, wrap=0, at_limit=0, regardless of load/en.
REQ-028 SHALL, when rst is asserted mid-count, discard the count and resume from 0 on the first edge after rst deasserts.
REQ-029 SHALL have tc follow REQ-021 during reset (q=0, so tc=1 when en=1, up=0, load=0).

Verification (WIDTH=4, MAX_VAL=9 unless stated)
REQ-030 SHALL cover: rst=1 for 2 edges, then en=1, up=1, sat=0 for 12 edges -> q runs 0..9,0,1; tc=1 while q=9; wrap=1 only the cycle q first reads 0 after 9.
REQ-031 SHALL cover: load=1, load_val=2, then up=0, en=1, sat=0 for 4 edges -> q = 2,1,0,9,8; wrap pulses once after the 0->9 edge.
REQ-032 SHALL cover: load_val=12 with load=1 -> q=9; then up=1, sat=1, en=1 for 3 edges -> q stays 9 and at_limit=1 from the first blocked edge; load_val=3 load -> q=3, at_limit=0.
REQ-033 SHALL cover: load=1 together with en=1, up=1 at q=5, load_val=7 -> q=7 (load wins); en=0 for 5 edges -> q stays 7, tc=0.
REQ-034 SHALL cover: q=6 counting, then rst=1 with load=1 and load_val=4 -> q=0, wrap=0, at_limit=0 (rst wins).
REQ-035 SHALL cover: WIDTH=4, MAX_VAL=15, up=1, sat=0 from 15 -> q=0 and wrap pulses; with sat=1 -> q holds 15.
